// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if
// Bundles the read, write and clear signals of the multi-port register file.
//
// Signals:
//   rdAddr   packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   rdData   packed read data, same packing as rdAddr
//   wrEnA/wrAddrA/wrDataA   write port A
//   wrEnB/wrAddrB/wrDataB   write port B (wins on an address clash)
//   clr      request a full clear (pulse or level)
//   busy     clear in progress
//
// Transfer semantics: this block has no valid/ready handshake. A write whose
// enable is high is committed at the rising clock edge if busy is low and clr
// is low in that cycle; otherwise it is silently dropped. Reads are
// combinational and always accepted; while busy is high they return zero.
//
// Modports: master drives addresses/writes/clr, slave is the register file.
// ---------------------------------------------------------------------------
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD*ADDR_W-1:0] rdAddr;
    logic [NRD*DATA_W-1:0] rdData;
    logic                  wrEnA;
    logic [ADDR_W-1:0]     wrAddrA;
    logic [DATA_W-1:0]     wrDataA;
    logic                  wrEnB;
    logic [ADDR_W-1:0]     wrAddrB;
    logic [DATA_W-1:0]     wrDataB;
    logic                  clr;
    logic                  busy;

    modport master (
        output rdAddr, wrEnA, wrAddrA, wrDataA, wrEnB, wrAddrB, wrDataB, clr,
        input  rdData, busy
    );

    modport slave (
        input  rdAddr, wrEnA, wrAddrA, wrDataA, wrEnB, wrAddrB, wrDataB, clr,
        output rdData, busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Parametrised multi-port architectural register file: NRD combinational
// read ports, two write ports (B has priority), optional write-to-read
// bypass, optional hardwired zero register and a sequenced hardware clear
// that runs after reset or on request.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset (restarts the clear sequence)
//   bus          reg_file_mp_if.slave: read/write/clear signals and busy
//   dbg_state_o  controller state, 1 = READY, 0 = CLEAR
//   dbg_ptr_o    clear pointer
// ---------------------------------------------------------------------------
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_file_mp_if.slave      bus,
    output logic              dbg_state_o,
    output logic [ADDR_W-1:0] dbg_ptr_o
);
    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_we;
    logic              busy;
    logic              wr_eff_a, wr_eff_b;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Controller next state. A clr seen while clearing restarts from zero
    // without writing, so the full DEPTH-cycle sweep always follows.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (bus.clr) begin
                    ptr_d = '0;
                end else begin
                    clr_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (ptr_q == LAST) begin
                        state_d = ST_READY;
                    end
                end
            end
            default: begin
                if (bus.clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy        = (state_q == ST_CLEAR);
    assign bus.busy    = busy;
    assign dbg_state_o = (state_q == ST_READY);
    assign dbg_ptr_o   = ptr_q;

    // A write is effective only when it will actually land in the array;
    // the same qualifier gates the bypass so a dropped write is never seen.
    assign wr_eff_a = bus.wrEnA && !busy && !bus.clr &&
                      !(ZERO_REG && (bus.wrAddrA == '0));
    assign wr_eff_b = bus.wrEnB && !busy && !bus.clr &&
                      !(ZERO_REG && (bus.wrAddrB == '0));

    // Storage has no reset: the sequencer zeroes it. Clear writes happen only
    // in CLEAR and port writes only in READY, so they never collide. Port B is
    // written last so it wins on an address clash.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem_q[ptr_q] <= '0;
            end
            if (wr_eff_a) begin
                mem_q[bus.wrAddrA] <= bus.wrDataA;
            end
            if (wr_eff_b) begin
                mem_q[bus.wrAddrB] <= bus.wrDataB;
            end
        end
    end

    // Read ports: later assignments override earlier ones, so the lowest
    // priority source comes first and busy is applied last.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = bus.rdAddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem_q[addr];
            if (BYPASS && wr_eff_a && (bus.wrAddrA == addr)) begin
                data = bus.wrDataA;
            end
            if (BYPASS && wr_eff_b && (bus.wrAddrB == addr)) begin
                data = bus.wrDataB;
            end
            if (ZERO_REG && (addr == '0)) begin
                data = '0;
            end
            if (busy) begin
                data = '0;
            end
        end

        assign bus.rdData[i*DATA_W +: DATA_W] = data;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
// Four register-file instances driven from one stimulus stream:
//   lane 0: NRD=2 ADDR_W=5 ZERO_REG=1 BYPASS=1
//   lane 1: NRD=2 ADDR_W=5 ZERO_REG=1 BYPASS=0
//   lane 2: NRD=2 ADDR_W=5 ZERO_REG=0 BYPASS=1
//   lane 3: NRD=4 ADDR_W=3 ZERO_REG=1 BYPASS=1 (addresses use the low 3 bits)
// A reference model tracks per lane the remaining clear cycles and the
// register contents; a negedge process compares every output every cycle.
// Directed steps add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;
    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_a [4];
    logic        wen_a, wen_b;
    logic [4:0]  wa_a, wa_b;
    logic [31:0] wd_a, wd_b;
    logic        clr;

    int n_cmp = 0;
    int n_bad = 0;

    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if0 ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if1 ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if2 ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(3), .NRD(4)) if3 ();

    logic       st0, st1, st2, st3;
    logic [4:0] pt0, pt1, pt2;
    logic [2:0] pt3;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .dbg_state_o(st0), .dbg_ptr_o(pt0));
    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .dbg_state_o(st1), .dbg_ptr_o(pt1));
    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave), .dbg_state_o(st2), .dbg_ptr_o(pt2));
    reg_file_mp #(.DATA_W(32), .ADDR_W(3), .NRD(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave), .dbg_state_o(st3), .dbg_ptr_o(pt3));

    // ---------------- shared stimulus fan-out ----------------
    assign if0.rdAddr  = {rd_a[1], rd_a[0]};
    assign if1.rdAddr  = {rd_a[1], rd_a[0]};
    assign if2.rdAddr  = {rd_a[1], rd_a[0]};
    assign if3.rdAddr  = {rd_a[3][2:0], rd_a[2][2:0], rd_a[1][2:0], rd_a[0][2:0]};
    assign if0.wrEnA = wen_a; assign if0.wrAddrA = wa_a; assign if0.wrDataA = wd_a;
    assign if1.wrEnA = wen_a; assign if1.wrAddrA = wa_a; assign if1.wrDataA = wd_a;
    assign if2.wrEnA = wen_a; assign if2.wrAddrA = wa_a; assign if2.wrDataA = wd_a;
    assign if3.wrEnA = wen_a; assign if3.wrAddrA = wa_a[2:0]; assign if3.wrDataA = wd_a;
    assign if0.wrEnB = wen_b; assign if0.wrAddrB = wa_b; assign if0.wrDataB = wd_b;
    assign if1.wrEnB = wen_b; assign if1.wrAddrB = wa_b; assign if1.wrDataB = wd_b;
    assign if2.wrEnB = wen_b; assign if2.wrAddrB = wa_b; assign if2.wrDataB = wd_b;
    assign if3.wrEnB = wen_b; assign if3.wrAddrB = wa_b[2:0]; assign if3.wrDataB = wd_b;
    assign if0.clr = clr; assign if1.clr = clr; assign if2.clr = clr; assign if3.clr = clr;

    logic [127:0] act_rd   [4];
    logic         act_busy [4];
    assign act_rd[0] = {64'h0, if0.rdData};
    assign act_rd[1] = {64'h0, if1.rdData};
    assign act_rd[2] = {64'h0, if2.rdData};
    assign act_rd[3] = if3.rdData;
    assign act_busy[0] = if0.busy;
    assign act_busy[1] = if1.busy;
    assign act_busy[2] = if2.busy;
    assign act_busy[3] = if3.busy;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int depth [4] = '{32, 32, 32, 8};
    int nrd   [4] = '{2, 2, 2, 4};
    bit zr    [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit byp   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int left  [4] = '{-1, -1, -1, -1};   // -1: state not yet known
    logic [31:0] mm [4][32];

    function automatic logic [31:0] exp_rd(int l, int p);
        int a, wa, wb;
        a  = int'(rd_a[p]) & (depth[l] - 1);
        wa = int'(wa_a) & (depth[l] - 1);
        wb = int'(wa_b) & (depth[l] - 1);
        if (left[l] != 0) return 32'h0;
        if (zr[l] && a == 0) return 32'h0;
        if (byp[l] && !clr && wen_b && wb == a) return wd_b;
        if (byp[l] && !clr && wen_a && wa == a) return wd_a;
        return mm[l][a];
    endfunction

    always @(posedge clk) begin
        int a, b;
        for (int l = 0; l < 4; l++) begin
            a = int'(wa_a) & (depth[l] - 1);
            b = int'(wa_b) & (depth[l] - 1);
            if (!rst_n) begin
                left[l] <= depth[l];
            end else if (left[l] > 0) begin
                if (clr) begin
                    left[l] <= depth[l];
                end else begin
                    left[l] <= left[l] - 1;
                    if (left[l] == 1) begin
                        for (int k = 0; k < 32; k++) mm[l][k] <= 32'h0;
                    end
                end
            end else if (left[l] == 0) begin
                if (clr) begin
                    left[l] <= depth[l];
                end else begin
                    if (wen_a && !(zr[l] && a == 0)) mm[l][a] <= wd_a;
                    if (wen_b && !(zr[l] && b == 0)) mm[l][b] <= wd_b;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (left[l] >= 0) begin
                chk($sformatf("lane%0d busy", l), 32'(act_busy[l]), 32'(left[l] > 0));
                for (int p = 0; p < nrd[l]; p++) begin
                    chk($sformatf("lane%0d rd%0d", l, p), act_rd[l][p*32 +: 32], exp_rd(l, p));
                end
                if (left[l] == 0) begin
                    chk($sformatf("lane%0d wren_known", l), 32'($isunknown({wen_a, wen_b})), 32'h0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        wen_a = 1'b0; wen_b = 1'b0;
        wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0;
    endtask

    // Counts consecutive busy cycles of lane 0 (and busy cycles of lane 3
    // in the same window); optionally pulses clr or rst_n in cycle restart_at.
    task automatic busy_run(input int restart_at, input bit use_rst,
                            output int n, output int n3);
        n = 0;
        n3 = 0;
        while (if0.busy && n < 200) begin
            n++;
            if (if3.busy) n3++;
            if (n == restart_at) begin
                if (use_rst) rst_n = 1'b0;
                else         clr = 1'b1;
            end
            step();
            rst_n = 1'b1;
            clr = 1'b0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, n3;
        rst_n = 1'b0;
        clr = 1'b0;
        idle_writes();
        for (int p = 0; p < 4; p++) rd_a[p] = '0;

        // 1. reset for two cycles, then the power-on clear
        step();
        step();
        rst_n = 1'b1;
        busy_run(0, 1'b0, n, n3);
        chk("reset busy cycles", 32'(n), 32'd32);
        chk("reset busy cycles lane3", 32'(n3), 32'd8);
        for (int a = 0; a < 32; a++) begin
            for (int p = 0; p < 4; p++) rd_a[p] = 5'(a + p);
            step();
        end
        rd_a[0] = 5'd31;
        #1;
        chk("post clear addr31", act_rd[0][31:0], 32'h0);

        // 2. basic write/read, old data visible in the write cycle without bypass
        wen_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
        rd_a[0] = 5'd5; rd_a[1] = 5'd5;
        #1;
        chk("nobyp old data", act_rd[1][31:0], 32'h0);
        chk("byp new data", act_rd[0][31:0], 32'hDEADBEEF);
        step();
        idle_writes();
        #1;
        chk("nobyp committed rd0", act_rd[1][31:0], 32'hDEADBEEF);
        chk("nobyp committed rd1", act_rd[1][63:32], 32'hDEADBEEF);

        // 3. same-address conflict, B wins in bypass and in storage
        step();
        wen_a = 1'b1; wa_a = 5'd7; wd_a = 32'h11111111;
        wen_b = 1'b1; wa_b = 5'd7; wd_b = 32'h22222222;
        rd_a[0] = 5'd7; rd_a[1] = 5'd5;
        #1;
        chk("conflict bypass", act_rd[0][31:0], 32'h22222222);
        chk("conflict nobyp old", act_rd[1][31:0], 32'h0);
        step();
        idle_writes();
        #1;
        chk("conflict stored", act_rd[1][31:0], 32'h22222222);

        // 4. zero register, with and without ZERO_REG
        step();
        wen_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFFFFFF;
        rd_a[0] = 5'd0;
        #1;
        chk("zero reg bypass", act_rd[0][31:0], 32'h0);
        chk("no zero reg bypass", act_rd[2][31:0], 32'hFFFFFFFF);
        step();
        idle_writes();
        #1;
        chk("zero reg after", act_rd[0][31:0], 32'h0);
        chk("no zero reg after", act_rd[2][31:0], 32'hFFFFFFFF);

        // 5. fill, then clear with a colliding write, then restart at cycle 10
        for (int a = 1; a < 32; a++) begin
            wen_a = 1'b1; wa_a = 5'(a); wd_a = 32'(a);
            rd_a[0] = 5'(a - 1); rd_a[1] = 5'(a);
            rd_a[2] = 5'(a + 3); rd_a[3] = 5'(a + 5);
            step();
        end
        wen_a = 1'b1; wa_a = 5'd3; wd_a = 32'h0000ABCD; clr = 1'b1;
        rd_a[0] = 5'd3;
        #1;
        chk("clr cycle write not bypassed", act_rd[0][31:0], 32'h3);
        step();
        clr = 1'b0;
        idle_writes();
        busy_run(10, 1'b0, n, n3);
        chk("clr restart busy cycles", 32'(n), 32'd42);
        for (int a = 0; a < 32; a++) begin
            for (int p = 0; p < 4; p++) rd_a[p] = 5'(31 - a + p);
            step();
        end
        rd_a[0] = 5'd3;
        #1;
        chk("addr3 after clear", act_rd[0][31:0], 32'h0);

        // 6. reset in clear cycle 20
        clr = 1'b1;
        step();
        clr = 1'b0;
        busy_run(20, 1'b1, n, n3);
        chk("reset mid clear busy cycles", 32'(n), 32'd52);

        // mixed traffic exercising all four ports of lane 3
        for (int i = 0; i < 16; i++) begin
            wen_a = 1'b1; wa_a = 5'(i); wd_a = 32'h10000000 + 32'(i);
            wen_b = (i % 3 == 0); wa_b = 5'(i + 1); wd_b = 32'hB0000000 + 32'(i);
            for (int p = 0; p < 4; p++) rd_a[p] = 5'(i + 2 * p);
            step();
        end
        idle_writes();
        rd_a[0] = 5'd1; rd_a[1] = 5'd2; rd_a[2] = 5'd3; rd_a[3] = 5'd4;
        #1;
        chk("lane3 port0", act_rd[3][31:0],   32'h10000009);
        chk("lane3 port1", act_rd[3][63:32],  32'h1000000A);
        chk("lane3 port2", act_rd[3][95:64],  32'h1000000B);
        chk("lane3 port3", act_rd[3][127:96], 32'h1000000C);
        rd_a[1] = 5'd16;
        #1;
        chk("lane0 B-only addr16", act_rd[0][63:32], 32'hB000000F);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
